simulador_carga_baterias: RTL
=============================

Name: simulador_carga_baterias

Overview:
Generates the two 4-bit charge levels (carga_bateria1, carga_bateria2) consumed by the discharged-battery detector. It models a dual-battery pack: load drains the active battery, automatic switchover to the second battery at empty, and a charger that refills the idle battery. A prescaler sets the model time step so the levels change at human-observable rates on the board.

Parameters:
TICKS_POR_PASO, 50000000, clock cycles per model step (>=2)
CARGA_INICIAL, 15, reset value of both charge levels (0..15)
UMBRAL_REARME, 4, b1 level needed to leave AGOTADO (1..15)
AUTODESCARGA_PASOS, 8, steps between self-discharge decrements (optional feature only, >=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
consumo  input  1  load connected; active battery drains while high
cargador  input  1  charger connected; idle battery charges while high
carga_bateria1  output  4  battery 1 charge level, 0=empty, 15=full
carga_bateria2  output  4  battery 2 charge level
bateria_activa  output  1  0=battery 1 feeds load, 1=battery 2
sin_energia  output  1  high in state AGOTADO
paso  output  1  one-cycle pulse on each model step

Behaviour:
- One clock, clk; reset is synchronous and active-high (rst). All state and outputs are registered.
- Reset values: carga_bateria1=carga_bateria2=CARGA_INICIAL, state USA_B1, bateria_activa=0, sin_energia=0, paso=0, prescaler=0. rst is sampled every cycle, including mid-step; it overrides everything.
- Prescaler: counts 0..TICKS_POR_PASO-1. paso=1 in the cycle after the count wraps, so the period is exactly TICKS_POR_PASO cycles. The first paso occurs TICKS_POR_PASO cycles after rst deasserts.
- Level updates occur only in the same cycle as paso. consumo and cargador are sampled in the paso cycle only.
- FSM states: USA_B1, USA_B2, AGOTADO.
- USA_B1:
  - If consumo, b1 <= b1-1, saturating at 0.
  - If cargador, b2 <= b2+1, saturating at 15.
  - Next state is evaluated on the updated b1. If b1'=0: go to USA_B2 when b2'>0, else go to AGOTADO.
- USA_B2: symmetric. b2 drains; b1 charges when cargador. If b2'=0, go to AGOTADO. Battery 1 is not auto-reselected while b2>0.
- AGOTADO:
  - No drain.
  - If cargador, b1 charges until 15. Once b1=15, b2 charges.
  - When b1' >= UMBRAL_REARME, go to USA_B1.
- Decrement and increment on different batteries in the same step are both applied.
- Saturation: never wrap 0->15 or 15->0.
- bateria_activa = 1 only in USA_B2. sin_energia = 1 only in AGOTADO. Both reflect the registered state and update the cycle after the paso that caused the transition.
- With consumo=0 and cargador=0, levels hold indefinitely.

Optional Feature:
- Macro: AUTODESCARGA_EN.
- Defined: a step counter counts model steps. Every AUTODESCARGA_PASOS steps, the idle battery (not active; in AGOTADO, both) loses 1, saturating at 0. This applies only when cargador=0 in that step. If self-discharge and charging both apply, charging wins and there is no decrement. A self-discharge that empties b2 while in USA_B1 causes no state change.
- Not defined: no self-discharge logic; the step counter is absent.

Test Plan:
1. TICKS_POR_PASO=4; assert rst 3 cycles, release, hold inputs low -> levels 15/15, bateria_activa=0, sin_energia=0. First paso pulse appears exactly 4 cycles after release, then every 4 cycles.
2. consumo=1, cargador=0 for 15 steps -> b1 counts 15..0. On the step where b1 reaches 0, next state is USA_B2, bateria_activa=1, and b2 is still 15.
3. Continue consumo=1 for 15 more steps -> b2 reaches 0, sin_energia=1. Further steps keep both at 0 with no wrap to 15.
4. From AGOTADO, consumo=0, cargador=1 -> b1 goes 1,2,3,4. On the step where b1=4 (UMBRAL_REARME), state returns to USA_B1 and sin_energia drops. Meanwhile b2 charges, reaching 15 and then holding.
5. In USA_B1 with b1=7, b2=14, consumo=1, cargador=1 for 2 steps -> b1=5, b2=15 (saturated). Assert rst mid-prescaler -> 15/15, USA_B1, prescaler restarts.
6. AUTODESCARGA_EN defined, AUTODESCARGA_PASOS=8, USA_B1, consumo=0, cargador=0 -> b2 drops by 1 every 8 steps and b1 is unchanged. With cargador=1, there is no self-discharge decrement.

Source files
------------

// File: rtl/simulador_carga_baterias.sv
// Dual-battery pack model feeding the discharged-battery detector.
// Battery 1 feeds the load first; at empty the pack switches to battery 2,
// and with both empty it sits in AGOTADO until the charger restores
// battery 1 to UMBRAL_REARME. A prescaler sets the model time step.
// Optional build macro AUTODESCARGA_EN adds periodic self-discharge of
// the idle battery every AUTODESCARGA_PASOS steps.
module simulador_carga_baterias #(
   parameter int unsigned TICKS_POR_PASO = 50000000,
   parameter int unsigned CARGA_INICIAL  = 15,
   parameter int unsigned UMBRAL_REARME  = 4
`ifdef AUTODESCARGA_EN
   , parameter int unsigned AUTODESCARGA_PASOS = 8
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       consumo,
   input  logic       cargador,
   output logic [3:0] carga_bateria1,
   output logic [3:0] carga_bateria2,
   output logic       bateria_activa,
   output logic       sin_energia,
   output logic       paso
);

   localparam int CW = $clog2(TICKS_POR_PASO);
   localparam logic [3:0] LLENA = 4'd15;
   localparam logic [3:0] VACIA = 4'd0;

   typedef enum logic [1:0] {USA_B1, USA_B2, AGOTADO} estado_t;

   estado_t        estado_q, estado_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           paso_q, paso_d;
   logic [3:0]     b1_q, b1_d;
   logic [3:0]     b2_q, b2_d;
   logic           activa_q, sin_q;
   logic           descarga;

`ifdef AUTODESCARGA_EN
   localparam int SW = (AUTODESCARGA_PASOS > 1) ? $clog2(AUTODESCARGA_PASOS) : 1;
   logic [SW-1:0]  pasos_q, pasos_d;
`endif

   // Next-state logic: prescaler, level updates and FSM transition on each step.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      cnt_d    = cnt_q + CW'(1);
      paso_d   = 1'b0;
      b1_d     = b1_q;
      b2_d     = b2_q;
      estado_d = estado_q;
      descarga = 1'b0;
`ifdef AUTODESCARGA_EN
      pasos_d  = pasos_q;
`endif
      if (cnt_q == CW'(TICKS_POR_PASO - 1)) begin
         cnt_d  = '0;
         paso_d = 1'b1;
`ifdef AUTODESCARGA_EN
         if (pasos_q == SW'(AUTODESCARGA_PASOS - 1)) begin
            pasos_d  = '0;
            // Charging takes precedence over self-discharge.
            descarga = !cargador;
         end else begin
            pasos_d  = pasos_q + SW'(1);
         end
`endif
         case (estado_q)
            USA_B1: begin
               if (consumo && b1_q != VACIA) b1_d = b1_q - 4'd1;
               if (cargador && b2_q != LLENA) b2_d = b2_q + 4'd1;
               else if (descarga && b2_q != VACIA) b2_d = b2_q - 4'd1;
               if (b1_d == VACIA) estado_d = (b2_d != VACIA) ? USA_B2 : AGOTADO;
            end
            USA_B2: begin
               if (consumo && b2_q != VACIA) b2_d = b2_q - 4'd1;
               if (cargador && b1_q != LLENA) b1_d = b1_q + 4'd1;
               else if (descarga && b1_q != VACIA) b1_d = b1_q - 4'd1;
               if (b2_d == VACIA) estado_d = AGOTADO;
            end
            AGOTADO: begin
               // Charger tops up battery 1 first, then battery 2.
               if (cargador) begin
                  if (b1_q != LLENA) b1_d = b1_q + 4'd1;
                  else if (b2_q != LLENA) b2_d = b2_q + 4'd1;
               end else if (descarga) begin
                  if (b1_q != VACIA) b1_d = b1_q - 4'd1;
                  if (b2_q != VACIA) b2_d = b2_q - 4'd1;
               end
               if (b1_d >= 4'(UMBRAL_REARME)) estado_d = USA_B1;
            end
            default: estado_d = USA_B1;
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         estado_q <= USA_B1;
         cnt_q    <= '0;
         paso_q   <= 1'b0;
         b1_q     <= 4'(CARGA_INICIAL);
         b2_q     <= 4'(CARGA_INICIAL);
         activa_q <= 1'b0;
         sin_q    <= 1'b0;
`ifdef AUTODESCARGA_EN
         pasos_q  <= '0;
`endif
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         paso_q   <= paso_d;
         b1_q     <= b1_d;
         b2_q     <= b2_d;
         // Status flags follow the registered state one cycle later.
         activa_q <= (estado_q == USA_B2);
         sin_q    <= (estado_q == AGOTADO);
`ifdef AUTODESCARGA_EN
         pasos_q  <= pasos_d;
`endif
      end
   end

   assign carga_bateria1 = b1_q;
   assign carga_bateria2 = b2_q;
   assign bateria_activa = activa_q;
   assign sin_energia    = sin_q;
   assign paso           = paso_q;

endmodule
